// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared state codes, region decode and counter widths for sys_bus.
package sys_bus_pkg;

    // FSM state codes (legacy-compatible constants)
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RAM_WAIT = 2'd1;
    localparam logic [1:0] ST_IO_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    localparam int unsigned IO_SIZE   = 256;
    localparam int unsigned WAIT_W    = 4;
    localparam int unsigned TIMEOUT_W = 16;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_RAM  = 2'd1,
        REG_IO   = 2'd2
    } region_t;

    // Window compares are done in 33 bits so a window ending at 4 GiB never wraps.
    function automatic region_t decode_region(
        input logic [31:0] addr,
        input logic [31:0] ram_base,
        input logic [32:0] ram_bytes,
        input logic [31:0] io_base
    );
        logic [32:0] a;
        a = {1'b0, addr};
        if (a >= {1'b0, ram_base} && a < ({1'b0, ram_base} + ram_bytes))
            return REG_RAM;
        if (a >= {1'b0, io_base} && a < ({1'b0, io_base} + 33'(IO_SIZE)))
            return REG_IO;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/sys_bus_sram.sv
// bus_sram: single-port word RAM, registered read, per-byte write enables.
module bus_sram #(
    parameter int unsigned WORDS = 4096
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [3:0]               we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [WORDS];

    // Byte-masked write and registered (read-before-write) read on enable
    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (we[b])
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sys_bus.sv
// sys_bus: memory-side bus target decoding requests to RAM, the IO window or
// unmapped space. Optional IO watchdog enabled by defining SYS_BUS_TIMEOUT_EN.
module sys_bus
    import sys_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS   = 4096,
    parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
    parameter logic [31:0] IO_BASE     = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        io_valid,
    input  logic        io_ready,
    output logic [7:0]  io_addr,
    input  logic [31:0] io_rdata,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_wstrb,
    output logic        bus_err
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

    logic [1:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [AW-1:0]     req_idx;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic [31:0]       rdata_q;
    logic              rd_from_ram;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;
    region_t           region;

`ifdef SYS_BUS_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] io_cnt;
`else
    // IO_WAIT waits for io_ready indefinitely; no watchdog counter.
`endif

    assign region = decode_region(mem_addr, RAM_BASE, RAM_BYTES, IO_BASE);

    // RAM is touched only in the final wait cycle; reset suppresses a pending write.
    assign ram_en = (state == ST_RAM_WAIT) && (wait_cnt == '0) && !rst;
    assign ram_we = ram_en ? req_wstrb : 4'b0000;

    // The RAM's registered read lands during RESP, so it is forwarded directly
    // then and copied into rdata_q so it holds until the next completion.
    assign mem_rdata = rd_from_ram ? ram_rdata : rdata_q;

    bus_sram #(.WORDS(RAM_WORDS)) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (req_idx),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    // Request FSM, IO port registers and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem_ready   <= 1'b0;
            rdata_q     <= '0;
            rd_from_ram <= 1'b0;
            io_valid    <= 1'b0;
            io_addr     <= '0;
            io_wdata    <= '0;
            io_wstrb    <= '0;
            bus_err     <= 1'b0;
            wait_cnt    <= '0;
            req_idx     <= '0;
            req_wdata   <= '0;
            req_wstrb   <= '0;
`ifdef SYS_BUS_TIMEOUT_EN
            io_cnt      <= '0;
`endif
        end else begin
            mem_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_valid) begin
                        rd_from_ram <= 1'b0;
                        case (region)
                            REG_RAM: begin
                                state     <= ST_RAM_WAIT;
                                wait_cnt  <= WAIT_W'(WAIT_STATES);
                                req_idx   <= AW'((mem_addr - RAM_BASE) >> 2);
                                req_wdata <= mem_wdata;
                                req_wstrb <= mem_wstrb;
                            end
                            REG_IO: begin
                                state    <= ST_IO_WAIT;
                                io_valid <= 1'b1;
                                io_addr  <= 8'(mem_addr - IO_BASE) & 8'hFC;
                                io_wdata <= mem_wdata;
                                io_wstrb <= mem_wstrb;
`ifdef SYS_BUS_TIMEOUT_EN
                                io_cnt   <= '0;
`endif
                            end
                            default: begin
                                state     <= ST_RESP;
                                mem_ready <= 1'b1;
                                rdata_q   <= '0;
                                bus_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RAM_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_RESP;
                        mem_ready <= 1'b1;
                        if (req_wstrb == 4'b0000)
                            rd_from_ram <= 1'b1;
                        else
                            rdata_q <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_IO_WAIT: begin
                    if (io_ready) begin
                        io_valid  <= 1'b0;
                        rdata_q   <= (io_wstrb == 4'b0000) ? io_rdata : '0;
                        state     <= ST_RESP;
                        mem_ready <= 1'b1;
                    end
`ifdef SYS_BUS_TIMEOUT_EN
                    else if (io_cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
                        io_valid  <= 1'b0;
                        rdata_q   <= '0;
                        bus_err   <= 1'b1;
                        state     <= ST_RESP;
                        mem_ready <= 1'b1;
                    end else begin
                        io_cnt <= io_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    rd_from_ram <= 1'b0;
                    if (rd_from_ram)
                        rdata_q <= ram_rdata;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bus.sv
// tb_sys_bus: randomized self-checking bench for sys_bus against a behavioural
// model (word array, region rules, latency formulas). Honours SYS_BUS_TIMEOUT_EN.
module tb_sys_bus;

    localparam int unsigned RAM_WORDS = 4096;
    localparam logic [31:0] RAM_END   = 32'(RAM_WORDS * 4);
    localparam logic [31:0] IO_BASE   = 32'h8000_0000;
    localparam int unsigned WS        = 1;
    localparam int unsigned TIMEOUT   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        io_valid;
    logic        io_ready;
    logic [7:0]  io_addr;
    logic [31:0] io_rdata;
    logic [31:0] io_wdata;
    logic [3:0]  io_wstrb;
    logic        bus_err;

    always #5 clk = ~clk;

    sys_bus #(
        .RAM_WORDS   (RAM_WORDS),
        .RAM_BASE    (32'h0000_0000),
        .IO_BASE     (IO_BASE),
        .WAIT_STATES (WS),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .io_valid  (io_valid),
        .io_ready  (io_ready),
        .io_addr   (io_addr),
        .io_rdata  (io_rdata),
        .io_wdata  (io_wdata),
        .io_wstrb  (io_wstrb),
        .bus_err   (bus_err)
    );

    int checks = 0;
    int errors = 0;

    // Peripheral responder controls and captured request fields
    logic        io_en    = 1'b1;
    int          io_delay = 1;
    logic [31:0] io_data  = '0;
    logic [7:0]  cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    // Reference state
    logic [31:0] ram_m [int];
    logic        err_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Peripheral: raise io_ready for one cycle after io_valid was seen io_delay cycles
    initial begin
        int seen;
        seen = 0;
        io_ready = 1'b0;
        io_rdata = '0;
        forever begin
            @(negedge clk);
            io_ready = 1'b0;
            if (io_valid && io_en) begin
                seen++;
                if (seen == io_delay) begin
                    io_ready  = 1'b1;
                    io_rdata  = io_data;
                    cap_addr  = io_addr;
                    cap_wdata = io_wdata;
                    cap_wstrb = io_wstrb;
                end
            end else begin
                seen = 0;
            end
        end
    end

    function automatic int exp_lat(input logic [31:0] a);
        if (a < RAM_END) return int'(WS) + 2;
        if (a >= IO_BASE && (a - IO_BASE) < 32'd256) return io_delay + 1;
        return 1;
    endfunction

    // Issue one request; lat = cycle index of mem_ready (valid-sample cycle = 0), -1 if none
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          output logic [31:0] rd, output int lat, output int vc);
        lat = -1;
        vc  = 0;
        rd  = '0;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        mem_valid = 1'b1;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (io_valid) vc++;
            if (mem_ready) begin
                lat = c;
                rd  = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
        if (lat > 0) begin
            @(negedge clk);
            check("ready_pulse", {31'd0, mem_ready}, 32'd0);
            check("rdata_hold", mem_rdata, rd);
        end
    endtask

    // Full transaction against the model
    task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] rd);
        logic [31:0] er;
        logic [31:0] w;
        int          lat;
        int          vc;
        int          el;
        int          idx;
        bit          known;
        bit          is_io;
        el    = exp_lat(a);
        er    = '0;
        known = 1'b1;
        is_io = 1'b0;
        if (a < RAM_END) begin
            idx = int'(a >> 2);
            if (ws == 4'b0000) begin
                if (ram_m.exists(idx)) er = ram_m[idx];
                else known = 1'b0;
            end else if (ram_m.exists(idx) || ws == 4'hF) begin
                w = ram_m.exists(idx) ? ram_m[idx] : 32'd0;
                for (int b = 0; b < 4; b++)
                    if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
                ram_m[idx] = w;
            end
        end else if (a >= IO_BASE && (a - IO_BASE) < 32'd256) begin
            is_io = 1'b1;
            er = (ws == 4'b0000) ? io_data : 32'd0;
        end else begin
            err_m = 1'b1;
        end
        do_req(a, wd, ws, rd, lat, vc);
        check({tag, "_lat"}, 32'(lat), 32'(el));
        if (known) check({tag, "_rdata"}, rd, er);
        check({tag, "_err"}, {31'd0, bus_err}, {31'd0, err_m});
        if (is_io) begin
            check({tag, "_ioaddr"}, {24'd0, cap_addr}, {24'd0, 8'(a - IO_BASE)});
            check({tag, "_iostrb"}, {28'd0, cap_wstrb}, {28'd0, ws});
            if (ws != 4'b0000) check({tag, "_iowdata"}, cap_wdata, wd);
            check({tag, "_iohold"}, 32'(vc), 32'(io_delay));
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        err_m = 1'b0;
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_iovalid", {31'd0, io_valid}, 32'd0);
        check("rst_err", {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          lat;
        int          vc;
        int          seen;
        int          widx [8];
        logic [31:0] unm [6];

        widx = '{0, 1, 4, 9, 100, 2047, 4094, 4095};
        unm  = '{32'h4000_0000, RAM_END, IO_BASE - 32'd4, IO_BASE + 32'd256,
                 32'hFFFF_FFFC, 32'h7FFF_FFFC};
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        mem_valid = 1'b0;
        err_m     = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", {31'd0, mem_ready}, 32'd0);
        check("reset_rdata", mem_rdata, 32'd0);
        check("reset_iovalid", {31'd0, io_valid}, 32'd0);
        check("reset_ioaddr", {24'd0, io_addr}, 32'd0);
        check("reset_iowstrb", {28'd0, io_wstrb}, 32'd0);
        check("reset_iowdata", io_wdata, 32'd0);
        check("reset_err", {31'd0, bus_err}, 32'd0);

        // Full-word write then read, byte strobes
        txn("t1_wr", 32'h10, 32'hDEADBEEF, 4'hF, rd);
        txn("t1_rd", 32'h10, 32'h0, 4'h0, rd);
        check("t1_const", rd, 32'hDEADBEEF);
        txn("t2_wr0", 32'h10, 32'h000000AA, 4'b0001, rd);
        txn("t2_rd0", 32'h10, 32'h0, 4'h0, rd);
        check("t2_const0", rd, 32'hDEADBEAA);
        txn("t2_wr1", 32'h10, 32'h11223344, 4'b1100, rd);
        txn("t2_rd1", 32'h10, 32'h0, 4'h0, rd);
        check("t2_const1", rd, 32'h1122BEAA);

        // IO read with a delayed peripheral
        io_delay = 5;
        io_data  = 32'h55;
        txn("t3_io", IO_BASE + 32'h4, 32'h0, 4'h0, rd);
        check("t3_const", rd, 32'h55);

        // Unmapped access: sticky error survives good traffic, reset clears it
        txn("t4_unm", 32'h4000_0000, 32'h0, 4'h0, rd);
        for (int i = 0; i < 10; i++) txn("t4_good", 32'h10, 32'h0, 4'h0, rd);
        check("t4_sticky", {31'd0, bus_err}, 32'd1);
        do_reset();

        // Seed model-known RAM words, then randomized traffic
        foreach (widx[i]) txn("seed", 32'(widx[i] * 4), $urandom, 4'hF, rd);
        for (int n = 0; n < 120; n++) begin
            int sel;
            sel = int'($urandom_range(0, 11));
            ws  = 4'($urandom);
            if ($urandom_range(0, 1) == 0) ws = 4'h0;
            wd  = $urandom;
            if (sel <= 5) begin
                a = 32'(widx[$urandom_range(0, 7)] * 4);
                txn("rnd_ram", a, wd, ws, rd);
            end else if (sel <= 8) begin
                io_delay = int'($urandom_range(1, 4));
                io_data  = $urandom;
                a = IO_BASE + 32'($urandom_range(0, 63) * 4);
                txn("rnd_io", a, wd, ws, rd);
            end else if (sel <= 10) begin
                txn("rnd_unm", unm[$urandom_range(0, 5)], wd, ws, rd);
            end else begin
                do_reset();
            end
        end
        do_reset();

        // Reset in the last RAM_WAIT cycle of a write aborts it
        txn("t6_seed", 32'h20, 32'h0BADF00D, 4'hF, rd);
        mem_addr  = 32'h20;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = 4'hF;
        mem_valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (mem_ready) seen++;
        end
        rst       = 1'b1;
        mem_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) rst = 1'b0;
            if (mem_ready) seen++;
        end
        check("t6_noready", 32'(seen), 32'd0);
        txn("t6_rd", 32'h20, 32'h0, 4'h0, rd);
        check("t6_const", rd, 32'h0BADF00D);

        // IO with a silent peripheral
        io_en = 1'b0;
`ifdef SYS_BUS_TIMEOUT_EN
        do_req(IO_BASE + 32'h8, 32'h0, 4'h0, rd, lat, vc);
        check("t5_lat", 32'(lat), 32'(TIMEOUT + 1));
        check("t5_iohold", 32'(vc), 32'(TIMEOUT));
        check("t5_rdata", rd, 32'd0);
        check("t5_err", {31'd0, bus_err}, 32'd1);
`else
        do_req(IO_BASE + 32'h8, 32'h0, 4'h0, rd, lat, vc);
        check("t5_noresp", 32'(lat), 32'hFFFF_FFFF);
        check("t5_iostill", {31'd0, io_valid}, 32'd1);
`endif
        io_en = 1'b1;
        do_reset();
        io_delay = 2;
        io_data  = 32'hCAFE_0001;
        txn("t5_after", IO_BASE + 32'hFC, 32'h0, 4'h0, rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
